// File: rtl/mproc_v2.sv
// mproc_v2: multi-cycle core with FETCH/EXEC/HALT, 8-entry regfile, ALU and carry.
// Ports: clk, reset (sync low), addr/ins_req/ins_valid/ins fetch, cout, halted, illegal, dbg_addr/dbg_data.
module mproc_v2 #(
  parameter int DW = 16,
  parameter int PCW = 16,
  parameter logic [PCW-1:0] RST_PC = '0
) (
  input  logic           clk,
  input  logic           reset,
  output logic [PCW-1:0] addr,
  output logic           ins_req,
  input  logic           ins_valid,
  input  logic [15:0]    ins,
  output logic           cout,
  output logic           halted,
  output logic           illegal,
  input  logic [2:0]     dbg_addr,
  output logic [DW-1:0]  dbg_data
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_JMP  = 5'b00010;
  localparam logic [4:0] OP_BZ   = 5'b00011;
  localparam logic [4:0] OP_HALT = 5'b11111;
  localparam logic [PCW-1:0] PC_ONE = PCW'(1);

  state_t         state_q;
  logic [PCW-1:0] pc_q;
  logic [15:0]    ir_q;
  logic [DW-1:0]  rf_q [8];
  logic           cout_q;
  logic           ins_req_q;
  logic           halted_q;
  logic           illegal_q;

  logic [PCW-1:0] pc_d;
  logic           cout_d;
  logic           wr_en;
  logic [2:0]     wr_idx;
  logic [DW-1:0]  wr_data;
  logic           go_halt;

  logic [DW-1:0]  opa;
  logic [DW-1:0]  opb;
  logic           is_sub;
  logic [DW:0]    sum;

  // Illegal is decided when the word is captured so it can be a
  // registered pulse covering exactly the EXEC cycle.
  function automatic logic bad_op(input logic [4:0] op);
    return !(op == OP_ALU || op == OP_LDI || op == OP_JMP ||
             op == OP_BZ || op == OP_HALT);
  endfunction

  assign opa    = rf_q[ir_q[2:0]];
  assign opb    = rf_q[ir_q[5:3]];
  assign is_sub = (ir_q[10:9] == 2'b01);
  // Subtract as a + ~b + 1 so carry-out means "no borrow".
  assign sum    = {1'b0, opa} + {1'b0, is_sub ? ~opb : opb}
                + {{DW{1'b0}}, is_sub};

  always_comb begin
    pc_d    = pc_q + PC_ONE;
    cout_d  = cout_q;
    wr_en   = 1'b0;
    wr_idx  = ir_q[8:6];
    wr_data = '0;
    go_halt = 1'b0;
    unique case (ir_q[15:11])
      OP_ALU: begin
        wr_en = 1'b1;
        unique case (ir_q[10:9])
          2'b00, 2'b01: begin
            wr_data = sum[DW-1:0];
            cout_d  = sum[DW];
          end
          2'b10: wr_data = opa & opb;
          default: wr_data = opa | opb;
        endcase
      end
      OP_LDI: begin
        wr_en   = 1'b1;
        wr_idx  = ir_q[10:8];
        wr_data = DW'(ir_q[7:0]);
      end
      OP_JMP: pc_d = PCW'(ir_q[10:0]);
      OP_BZ: begin
        if (opa == '0)
          pc_d = pc_q + PCW'($signed(ir_q[10:3]));
      end
      OP_HALT: begin
        pc_d    = pc_q;
        go_halt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= FETCH;
      pc_q      <= RST_PC;
      ir_q      <= '0;
      cout_q    <= 1'b0;
      ins_req_q <= 1'b1;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 8; i++)
        rf_q[i] <= '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (ins_valid) begin
            ir_q      <= ins;
            illegal_q <= bad_op(ins[15:11]);
            ins_req_q <= 1'b0;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          pc_q      <= pc_d;
          cout_q    <= cout_d;
          illegal_q <= 1'b0;
          if (wr_en)
            rf_q[wr_idx] <= wr_data;
          if (go_halt) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else begin
            state_q   <= FETCH;
            ins_req_q <= 1'b1;
          end
        end
        HALT: ;
        default: begin
          state_q   <= FETCH;
          ins_req_q <= 1'b1;
          halted_q  <= 1'b0;
          illegal_q <= 1'b0;
        end
      endcase
    end
  end

  assign addr     = pc_q;
  assign ins_req  = ins_req_q;
  assign cout     = cout_q;
  assign halted   = halted_q;
  assign illegal  = illegal_q;
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: doc/mproc_v2.md
Name: mproc_v2

Overview:
- Parametrised second-generation multi-cycle processor core: 16-bit instruction register, PC, 8-entry register file and ALU.
- Fetches over a request/valid handshake, then executes in a separate cycle.
- Adds load-immediate, absolute jump, branch-on-zero, halt, a registered carry flag and a debug register-read port.
- Sits between the instruction memory model and the lab top level; replaces the fixed-width ALU-only core.

Parameters:
- DW, 16, data/register width; legal 8..64.
- PCW, 16, PC/address width; legal 11..32.
- RST_PC, 0, PC value loaded on reset; PCW bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk edge.
- addr  out  PCW  current PC, driven straight from the PC register.
- ins_req  out  1  fetch request; high exactly while state==FETCH.
- ins_valid  in  1  instruction memory response strobe for the current addr.
- ins  in  16  instruction word, valid when ins_valid=1.
- cout  out  1  registered carry flag.
- halted  out  1  high while state==HALT.
- illegal  out  1  one-cycle pulse in EXEC for an undefined opcode.
- dbg_addr  in  3  debug register select.
- dbg_data  out  DW  combinational read of reg[dbg_addr].

Behaviour:
- Reset (reset==0 at posedge):
  - state=FETCH, PC=RST_PC, IR=0, all regs=0, cout=0.
  - Overrides every other event, including a write pending in EXEC; no register write occurs that cycle.
  - ins_valid is ignored while reset==0.
- Outputs after reset: addr=RST_PC, ins_req=1, halted=0, illegal=0, cout=0.
- States: FETCH, EXEC, HALT.
  - FETCH: hold addr and ins_req=1. On ins_valid=1, IR<=ins and go to EXEC. Otherwise stay; no timeout.
  - EXEC: decode IR[15:11], perform the action in one cycle, update PC, then go to FETCH (HALT for the halt opcode).
  - HALT: ins_req=0, PC and regs frozen, halted=1. Exit only by reset.
- Minimum two cycles per instruction; one extra cycle per cycle of ins_valid wait.
- Register reads are taken from pre-edge contents in EXEC. A write lands at the EXEC→FETCH edge.
- Encoding by IR[15:11]:
  - 00000 ALU: op=[10:9], rd=[8:6], rb=[5:3], ra=[2:0]; reg[rd]<=ra op rb; PC+1.
    - op 00 add: cout<=carry out of bit DW-1.
    - op 01 sub: computed as ra+~rb+1; cout<=carry out (1 when ra>=rb unsigned).
    - op 10 and, op 11 or: cout unchanged.
  - 00001 LDI: rd=[10:8]; reg[rd]<=zero-extended imm8=[7:0]; PC+1.
  - 00010 JMP: PC<=zero-extended [10:0].
  - 00011 BZ: ra=[2:0], off=[10:3] signed 8-bit.
    - reg[ra]==0: PC<=PC+sign-extended off.
    - Otherwise PC<=PC+1.
  - 11111 HALT: PC unchanged; go to HALT.
  - Any other code: no write, PC+1, illegal=1 for the EXEC cycle.
- Arithmetic:
  - ALU results truncated to DW.
  - All PC arithmetic modulo 2^PCW; PC+1 at all-ones wraps to 0; a negative branch below 0 wraps.
- Register 0 is an ordinary writable register.
- rd equal to ra or rb: the old value is used as the operand, the new value is written.
- dbg_data reflects a write starting the cycle after the EXEC edge.

Test Plan:
- Reset low for 2 cycles, release, ins_valid held 0 for 3 cycles → addr=RST_PC, ins_req=1, FETCH holds, no state change; all dbg_data=0.
- LDI r1,0xFF; LDI r2,0x01; ADD r3=r1+r2 (op 00, DW=16) → r3=0x0100, cout=0. Then LDI r4,0xFF, SUB r5=r2−r4 → r5=0xFF02, cout=0. Then SUB r6=r4−r2 → r6=0x00FE, cout=1.
- DW=8 build: LDI r1,0xFF; LDI r2,0x01; ADD r3=r1+r2 → r3=0x00, cout=1 (wrap and carry).
- BZ on reg=0 with off=−2 at PC=5 → next addr=3. BZ on reg≠0 → addr=6. JMP 0x7FF → addr=0x07FF. PCW=11, RST_PC=0x7FF, NOP → addr wraps to 0.
- Opcode 10101 → illegal pulses exactly 1 cycle, addr+1, regs unchanged. HALT → halted=1, ins_req=0, addr frozen for 10 cycles with ins_valid toggling.
- Reset asserted in EXEC of ADD r3 → r3 stays 0, addr=RST_PC next cycle. Independently, ins_valid delayed 4 cycles in FETCH → IR captured only on the valid cycle.
